// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and default parameters for the serial receiver
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_PARITY_EN    = 1;

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - loadable down-counter; o_expire is high while the count sits at zero
module serial_bit_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == '0);

endmodule

// File: rtl/serial_rx_ctrl.sv
// rtl/serial_rx_ctrl.sv - serial frame receiver: start qualify, mid-bit sampling, even parity,
// stop check and a one-entry valid/ready output buffer
module serial_rx_ctrl
  import serial_rx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = DEF_PARITY_EN
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_err_parity,
  output logic              o_err_frame,
  output logic              o_overrun
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_t          r_state;
  rx_state_t          w_next;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_next;
  logic [IDX_W-1:0]   r_bit_idx;
  logic               r_par_err;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic               r_err_parity;
  logic               r_err_frame;
  logic               r_overrun;

  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_expire;
  logic               w_shift_en;
  logic               w_par_en;
  logic               w_clr;
  logic               w_stop;
  logic               w_good;
  logic               w_buf_load;

  serial_bit_timer #(.W(TMR_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = FULL_BIT;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_clr      = 1'b0;
    w_stop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_in) begin
          w_next     = START;
          w_tmr_load = 1'b1;
          w_tmr_val  = HALF_BIT;
        end
      end
      START: begin
        if (w_expire) begin
          if (i_in) begin
            w_next = IDLE;
          end else begin
            w_next     = DATA;
            w_tmr_load = 1'b1;
            w_clr      = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_expire) begin
          w_shift_en = 1'b1;
          w_tmr_load = 1'b1;
          if (r_bit_idx == LAST_IDX) begin
            w_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_expire) begin
          w_par_en   = 1'b1;
          w_tmr_load = 1'b1;
          w_next     = STOP;
        end
      end
      STOP: begin
        if (w_expire) begin
          w_stop = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // LSB first: each new bit enters at the top and walks down to bit 0
  always_comb begin
    w_shift_next             = r_shift >> 1;
    w_shift_next[DATA_W-1]   = i_in;
  end

  assign w_good     = w_stop & i_in & ~r_par_err;
  assign w_buf_load = w_good & (~r_valid | i_ready);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_par_err    <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
      r_overrun    <= 1'b0;
      if (w_clr) begin
        r_bit_idx <= '0;
        r_par_err <= 1'b0;
      end
      if (w_shift_en) begin
        r_shift   <= w_shift_next;
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_par_en) begin
        r_par_err <= ^{r_shift, i_in};
      end
      // A bad stop bit hides any parity result for the same frame
      if (w_stop && !i_in) begin
        r_err_frame <= 1'b1;
      end else if (w_stop && r_par_err) begin
        r_err_parity <= 1'b1;
      end else if (w_good && !w_buf_load) begin
        r_overrun <= 1'b1;
      end
      if (w_buf_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data_out   = r_data;
  assign o_valid      = r_valid;
  assign o_busy       = (r_state != IDLE);
  assign o_err_parity = r_err_parity;
  assign o_err_frame  = r_err_frame;
  assign o_overrun    = r_overrun;

endmodule

// File: doc/serial_rx_ctrl.md
# serial_rx_ctrl

Controller that sequences reception of a bit-serial frame on the single-bit `in` line: start-bit qualification, mid-bit sampling, LSB-first data shift, optional even parity, and stop-bit check. The received word goes into a one-entry output buffer and is presented with a valid/ready handshake. The block sits between a single-bit serial input and any word-level consumer, and supplies the frame-level control that a bare bit-level state machine lacks.

## Interface
- `DATA_W`, default 8: data bits per frame, ≥1.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; must be even and ≥2.
- `PARITY_EN`, default 1: 1 means an even-parity bit follows the data; 0 means no parity bit.
- `clk` input, 1 bit: single clock; everything is rising-edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in` input, 1 bit: serial line. Idles high. Already synchronous to `clk`; there is no internal synchroniser.
- `data_out` output, `DATA_W` bits: buffered word, stable while `valid` is high.
- `valid` output, 1 bit: buffer holds a word.
- `ready` input, 1 bit: consumer accepts the word on a cycle where `valid && ready`.
- `busy` output, 1 bit: state is not IDLE.
- `err_parity` output, 1 bit: one-cycle pulse, parity mismatch; the frame is dropped.
- `err_frame` output, 1 bit: one-cycle pulse, stop bit sampled 0; the frame is dropped.
- `overrun` output, 1 bit: one-cycle pulse, a good frame completed while the buffer was full and not draining; the new frame is dropped.

## Operation
- **States** (enum `rx_state_t`): IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `in==0` on a cycle moves to START. The bit timer loads `CLKS_PER_BIT/2 - 1`.
- **START:** at timer expiry, resample `in`.
  - `in==1` is a false start: go to IDLE with no error.
  - `in==0`: go to DATA. Timer loads `CLKS_PER_BIT - 1` and the bit index is cleared.
- **DATA:** at each timer expiry, sample `in` into the shift register, LSB first.
  - After bit `DATA_W-1`, go to PARITY if `PARITY_EN`, otherwise to STOP.
  - Timer reloads `CLKS_PER_BIT - 1` on every expiry.
- **PARITY:** at timer expiry, sample the parity bit. A mismatch (XOR of data and parity bit = 1) is recorded. Go to STOP.
- **STOP:** at timer expiry, sample `in` and go to IDLE. Priority of outcomes:
  - `in==0` gives `err_frame` (it takes precedence over parity error, and only `err_frame` pulses);
  - else a recorded parity mismatch gives `err_parity`;
  - else the frame is good.
- **Good frame, load rule:** the word is loaded into the buffer if the buffer is empty, or if `valid && ready` in the same cycle. Otherwise `overrun` pulses and the old word is kept.
- **Back-to-back frames:** IDLE is re-entered directly from STOP, so a start bit in the next cycle is accepted.
- **Handshake:**
  - `valid` deasserts the cycle after `valid && ready`, unless a load occurs in that same cycle.
  - If a load occurs in that cycle, `valid` stays high and `data_out` updates.
  - `ready` is ignored while `valid==0`.
- **Width rules:**
  - Bit timer width: `$clog2(CLKS_PER_BIT)`.
  - Bit index width: `$clog2(DATA_W+1)`.
  - Parity: XOR reduction over `DATA_W` bits plus the parity bit.

## Timing
- **Cycle 0** is the first edge at which `in==0` is seen in IDLE. With C = `CLKS_PER_BIT`:
  - start bit resampled at cycle C/2;
  - data bit i sampled at C/2 + (i+1)·C;
  - parity bit sampled at C/2 + (DATA_W+1)·C;
  - stop bit sampled at C/2 + (DATA_W+1+PARITY_EN)·C.
- `valid`, `err_*` and `overrun` are registered and assert one cycle after the stop sample.
- **Reset values:**
  - `data_out`=0, `valid`=0, `busy`=0, `err_parity`=0, `err_frame`=0, `overrun`=0;
  - state IDLE, buffer empty.
- **Reset mid-frame:** the frame is aborted and no pulse or `valid` is produced. The first start detection can occur the cycle after `reset` deasserts.
- `busy` is registered and is high from cycle 1 through the stop-sample cycle inclusive.

## Structure
- **Package `serial_rx_pkg`:** `rx_state_t` (enum logic [2:0]) and the default parameter constants.
- **Sub-module `serial_bit_timer`:** loadable down-counter with an expiry strobe. It is the only natural split.
- The shift register, parity accumulator, output buffer and FSM stay in `serial_rx_ctrl`.

## Test plan
All scenarios use DATA_W=8, C=4, PARITY_EN=1 unless stated.
- **Good frame:** send 0xA5, LSB first, parity 0, stop 1, `ready`=1. Expect `valid` for 1 cycle at cycle 43 with `data_out`=0xA5 and no error pulses.
- **False start:** `in` low for 1 cycle, then high. Expect return to IDLE, `busy` low by cycle 3, no `valid`, no errors.
- **Parity error:** send 0x01 with parity bit 0. Expect `err_parity` pulse at cycle 43 and `valid` stays 0. Repeat with stop bit 0: expect only `err_frame`.
- **Overrun / simultaneous:** send 0x3C then 0xC3 back-to-back with `ready`=0. Expect `overrun` at the second completion and `data_out`=0x3C. Repeat with `ready` raised exactly at the second load cycle: expect `valid` stays high, `data_out`=0xC3, no `overrun`.
- **Reset mid-frame:** assert `reset` at cycle 20 of a frame. Expect all outputs 0 the next cycle. A fresh 0x5A frame after release is received correctly.
- **PARITY_EN=0, C=2:** send 0xFF. Expect `valid` at cycle 20 with `data_out`=0xFF.
